// File: rtl/fepow.sv
// fepow: base^exponent mod 2^255-19 by MSB-first square-and-multiply.
// Ports: clock/reset_n, start/base/exponent in, done/out result,
//   mul_start/mul_a/mul_b out to and mul_done/mul_out in from a field multiplier.
module fepow #(
    parameter int EXP_BITS = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [254:0]        base,
    input  logic [EXP_BITS-1:0] exponent,
    output logic                done,
    output logic [254:0]        out,
    output logic                mul_start,
    output logic [254:0]        mul_a,
    output logic [254:0]        mul_b,
    input  logic                mul_done,
    input  logic [254:0]        mul_out
);

    localparam int IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);
    localparam logic [254:0] ONE = 255'd1;

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [254:0]        r_base;
    logic [254:0]        r_acc;
    logic [254:0]        r_out;
    logic [254:0]        r_mul_a;
    logic [254:0]        r_mul_b;
    logic [EXP_BITS-1:0] r_exp;
    logic [IDX_W-1:0]    r_idx;
    logic                r_done;
    logic                r_md_q;

    logic                w_rise;
    logic                w_accept;
    logic                w_capture;
    logic                w_step;
    logic                w_finish;
    logic                w_op_load;
    logic [254:0]        w_op_a;
    logic [254:0]        w_op_b;

    // Only a fresh 0->1 transition counts; a level left high by the
    // previous product is still in r_md_q and is rejected.
    assign w_rise    = mul_done & ~r_md_q;
    assign w_finish  = w_step && (r_idx == '0);
    assign mul_start = (r_state == SQ_ISSUE) || (r_state == MUL_ISSUE);
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign done      = r_done;
    assign out       = r_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands are loaded on the edge entering an ISSUE state, so they
    // are already valid during the mul_start cycle and hold through WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        w_op_load   = 1'b0;
        w_op_a      = mul_out;
        w_op_b      = mul_out;
        unique case (r_state)
            IDLE, FINISH: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SQ_ISSUE;
                    w_op_load   = 1'b1;
                    w_op_a      = ONE;
                    w_op_b      = ONE;
                end
            end
            SQ_ISSUE: w_state_nxt = SQ_WAIT;
            SQ_WAIT: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                    if (r_exp[r_idx]) begin
                        w_state_nxt = MUL_ISSUE;
                        w_op_load   = 1'b1;
                        w_op_b      = r_base;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            MUL_ISSUE: w_state_nxt = MUL_WAIT;
            MUL_WAIT: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                    w_step    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_step) begin
            if (r_idx == '0) begin
                w_state_nxt = FINISH;
            end else begin
                w_state_nxt = SQ_ISSUE;
                w_op_load   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_base  <= '0;
            r_exp   <= '0;
            r_acc   <= ONE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_md_q  <= 1'b0;
        end else begin
            r_md_q <= mul_done;
            if (w_accept) begin
                r_base <= base;
                r_exp  <= exponent;
                r_acc  <= ONE;
                r_idx  <= IDX_TOP;
                r_done <= 1'b0;
            end
            if (w_op_load) begin
                r_mul_a <= w_op_a;
                r_mul_b <= w_op_b;
            end
            if (w_capture) begin
                r_acc <= mul_out;
            end
            if (w_step && (r_idx != '0)) begin
                r_idx <= r_idx - 1'b1;
            end
            if (w_finish) begin
                r_out  <= mul_out;
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fepow.sv
// tb_fepow: directed checks of fepow against a behavioural
// mod 2^255-19 multiplier with fixed latency, pulse or level done.
module tb_fepow;

    localparam int LAT = 3;
    localparam int BUDGET = 10000;
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [254:0] base = '0;
    logic [254:0] exponent = '0;
    logic         done;
    logic [254:0] out;
    logic         mul_start;
    logic [254:0] mul_a;
    logic [254:0] mul_b;
    logic         mul_done = 1'b0;
    logic [254:0] mul_out = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int stab_viol = 0;
    int cnt = 0;
    bit level_mode = 1'b0;
    logic [254:0] r_a = '0;
    logic [254:0] r_b = '0;

    fepow dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base      (base),
        .exponent  (exponent),
        .done      (done),
        .out       (out),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_out   (mul_out)
    );

    always #5 clock = ~clock;

    function automatic logic [254:0] fmul(input logic [254:0] a,
                                          input logic [254:0] b);
        logic [509:0] pr;
        logic [260:0] t;
        logic [255:0] u;
        pr = {255'b0, a} * {255'b0, b};
        t = {6'b0, pr[254:0]} + {6'b0, pr[509:255]} * 261'd19;
        u = {1'b0, t[254:0]} + {250'b0, t[260:255]} * 256'd19;
        if (u >= P) u = u - P;
        if (u >= P) u = u - P;
        return u[254:0];
    endfunction

    always @(posedge clock) begin
        if (mul_start) begin
            pulses <= pulses + 1;
            r_a    <= mul_a;
            r_b    <= mul_b;
            cnt    <= LAT;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == LAT) mul_done <= 1'b0;
            if (cnt == 1) begin
                mul_done <= 1'b1;
                mul_out  <= fmul(r_a, r_b);
            end
        end else begin
            mul_done <= level_mode;
        end
        if (reset_n && cnt > 0 && !mul_start &&
            (mul_a !== r_a || mul_b !== r_b))
            stab_viol <= stab_viol + 1;
    end

    task automatic run_op(input logic [254:0] b, input logic [254:0] e,
                          output logic [254:0] res, output int np);
        int p0;
        bit seen;
        p0 = pulses;
        seen = 1'b0;
        @(negedge clock);
        start = 1'b1;
        base = b;
        exponent = e;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_fall: got %b want 0", done);
        end
        for (int i = 0; i < BUDGET; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", BUDGET);
        end
        res = out;
        np = pulses - p0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({done, mul_start} !== 2'b00 || out !== '0 ||
            mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL reset_outs: done=%b ms=%b out=%h a=%h b=%h",
                     done, mul_start, out, mul_a, mul_b);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (done !== 1'b0 || mul_start !== 1'b0 || pulses !== 0) begin
            errors++;
            $display("FAIL idle_quiet: done=%b ms=%b pulses=%0d want 0",
                     done, mul_start, pulses);
        end
    endtask

    task automatic test_pow_small;
        logic [254:0] r;
        int np;
        run_op(255'd3, 255'd4, r, np);
        checks++;
        if (r !== 255'd81) begin
            errors++;
            $display("FAIL pow_3_4: got %0d want 81", r);
        end
        checks++;
        if (np !== 256) begin
            errors++;
            $display("FAIL pulses_3_4: got %0d want 256", np);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (done !== 1'b1 || out !== 255'd81 || mul_start !== 1'b0) begin
            errors++;
            $display("FAIL hold_3_4: done=%b out=%0d ms=%b want 1/81/0",
                     done, out, mul_start);
        end
    endtask

    task automatic test_zero_exp;
        logic [254:0] r;
        int np;
        run_op(255'd5, 255'd0, r, np);
        checks++;
        if (r !== 255'd1) begin
            errors++;
            $display("FAIL pow_5_0: got %0d want 1", r);
        end
        checks++;
        if (np !== 255) begin
            errors++;
            $display("FAIL pulses_5_0: got %0d want 255", np);
        end
    endtask

    task automatic test_inverse;
        logic [254:0] r;
        logic [254:0] e;
        logic [254:0] want;
        int np;
        e = {250'h3ffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffff, 5'h0b};
        want = {251'h3ffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffff, 4'h7} >> 1;
        want[254] = 1'b0;
        want = 255'h3ffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffff7;
        run_op(255'd2, e, r, np);
        checks++;
        if (r !== want) begin
            errors++;
            $display("FAIL inv_2: got %h want %h", r, want);
        end
        checks++;
        if (np !== 508) begin
            errors++;
            $display("FAIL pulses_inv: got %0d want 508", np);
        end
    endtask

    task automatic test_start_ignored;
        int p0;
        bit seen;
        p0 = pulses;
        seen = 1'b0;
        @(negedge clock);
        start = 1'b1;
        base = 255'd3;
        exponent = 255'd4;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mul_start === 1'b1) seen = 1'b1;
            @(negedge clock);
        end
        start = 1'b1;
        base = 255'd7;
        exponent = 255'd1;
        @(negedge clock);
        start = 1'b0;
        base = '0;
        exponent = '0;
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clock);
        end
        checks++;
        if (!seen || out !== 255'd81) begin
            errors++;
            $display("FAIL start_ignored: done=%b out=%0d want 1/81", done, out);
        end
        checks++;
        if (pulses - p0 !== 256) begin
            errors++;
            $display("FAIL pulses_ignored: got %0d want 256", pulses - p0);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [254:0] r;
        int np;
        int p0;
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        start = 1'b1;
        base = 255'd3;
        exponent = 255'd4;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            if (mul_start === 1'b1 && mul_a !== mul_b) seen = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL find_mul_issue: not seen within %0d", BUDGET);
        end
        reset_n = 1'b0;
        p0 = pulses;
        #1;
        checks++;
        if ({done, mul_start} !== 2'b00 || out !== '0 ||
            mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL async_reset: done=%b ms=%b out=%h a=%h b=%h",
                     done, mul_start, out, mul_a, mul_b);
        end
        repeat (6) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if ({done, mul_start} !== 2'b00 || out !== '0 ||
            mul_a !== '0 || mul_b !== '0 || pulses !== p0) begin
            errors++;
            $display("FAIL post_reset: done=%b ms=%b out=%h a=%h pulses=%0d want %0d",
                     done, mul_start, out, mul_a, pulses, p0);
        end
        run_op(255'd3, 255'd2, r, np);
        checks++;
        if (r !== 255'd9 || np !== 256) begin
            errors++;
            $display("FAIL pow_3_2: got %0d/%0d want 9/256", r, np);
        end
    endtask

    task automatic test_level_done;
        logic [254:0] r;
        int np;
        level_mode = 1'b1;
        repeat (4) @(negedge clock);
        run_op(255'd3, 255'd4, r, np);
        checks++;
        if (r !== 255'd81 || np !== 256) begin
            errors++;
            $display("FAIL level_3_4: got %0d/%0d want 81/256", r, np);
        end
        level_mode = 1'b0;
    endtask

    initial begin
        test_reset;
        test_pow_small;
        test_zero_exp;
        test_inverse;
        test_start_ignored;
        test_reset_mid_op;
        test_level_done;
        checks++;
        if (stab_viol !== 0) begin
            errors++;
            $display("FAIL operand_stable: %0d violations want 0", stab_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
